// File: rtl/cl2_pl_exu_regfile_mp.sv
// Multi-port integer register file for the CL2 EXU. It has an optional
// write-to-read bypass and a per-register busy scoreboard for RAW detection.
module cl2_pl_exu_regfile_mp #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM       = 32,
  parameter int unsigned IDXW      = $clog2(NUM),
  parameter int unsigned NRD       = 2,
  parameter int unsigned NWR       = 1,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tm_i,
  input  logic [NRD*IDXW-1:0]  rd_idx_i,
  output logic [NRD*XLEN-1:0]  rd_dat_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*IDXW-1:0]  wr_idx_i,
  input  logic [NWR*XLEN-1:0]  wr_dat_i,
  input  logic                 set_en_i,
  input  logic [IDXW-1:0]      set_idx_i,
  input  logic                 flush_i,
  output logic [NUM-1:0]       busy_vec_o,
  output logic [IDXW:0]        busy_cnt_o
);

  logic [XLEN-1:0] regs [NUM];
  logic [NUM-1:0]  busy_q;
  logic [NUM-1:0]  busy_nxt;
  logic [IDXW:0]   cnt_q;

  logic [IDXW-1:0] wr_idx [NWR];
  logic [XLEN-1:0] wr_dat [NWR];
  logic [NWR-1:0]  wr_act;

  // tm_i is a DFT hook with no functional use.
  logic unused_tm;
  assign unused_tm = tm_i;

  for (genvar w = 0; w < NWR; w++) begin : g_wr_unpack
    assign wr_idx[w] = wr_idx_i[w*IDXW +: IDXW];
    assign wr_dat[w] = wr_dat_i[w*XLEN +: XLEN];
    assign wr_act[w] = wr_en_i[w] && (wr_idx_i[w*IDXW +: IDXW] != '0);
  end

  function automatic logic [IDXW:0] popcount(input logic [NUM-1:0] v);
    logic [IDXW:0] c;
    c = '0;
    for (int i = 0; i < NUM; i++) c = c + {{IDXW{1'b0}}, v[i]};
    return c;
  endfunction

  // NOTE: this array has an asynchronous reset so that every register reads 0
  // after reset. That stops it mapping to RAM. Reset is required here.
  // Ports are walked in ascending order, so the highest port's
  // non-blocking write is the one that lands when indices collide.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NUM; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_act[w]) regs[wr_idx[w]] <= wr_dat[w];
      end
    end
  end

  // Priority is flush > set > writeback clear. Set wins over clear because a
  // new producer can issue in the same cycle the old one retires.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_act[w]) busy_nxt[wr_idx[w]] = 1'b0;
    end
    if (set_en_i && (set_idx_i != '0)) busy_nxt[set_idx_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only. The count is
  // taken from busy_nxt, so it always agrees with busy_q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= popcount(busy_nxt);
    end
  end

  assign busy_vec_o = busy_q;
  assign busy_cnt_o = cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] dat;
    logic            bsy;

    assign idx = rd_idx_i[p*IDXW +: IDXW];

    // NOTE: every output gets a default first, so no latch is inferred.
    // Outputs are also gated with reset so a bypass hit cannot leak data
    // while reset is held.
    always_comb begin
      dat = regs[idx];
      bsy = busy_q[idx];
      if (BYPASS_EN != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_act[w] && (wr_idx[w] == idx)) begin
            dat = wr_dat[w];
            bsy = 1'b0;
          end
        end
      end
      if (!rst_n_i) begin
        dat = '0;
        bsy = 1'b0;
      end
    end

    assign rd_dat_o[p*XLEN +: XLEN] = dat;
    assign rd_busy_o[p]             = bsy;
  end

endmodule

// File: tb/tb_cl2_pl_exu_regfile_mp.sv
// Directed bench for cl2_pl_exu_regfile_mp. One instance has the bypass and one
// does not; both share the same stimulus, with two read and two write ports.
module tb_cl2_pl_exu_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tm;
  logic [9:0]  rd_idx;
  logic [63:0] rd_dat_b, rd_dat_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_idx;
  logic [63:0] wr_dat;
  logic        set_en;
  logic [4:0]  set_idx;
  logic        flush;
  logic [31:0] bv_b, bv_n;
  logic [5:0]  cnt_b, cnt_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cl2_pl_exu_regfile_mp #(.XLEN(32), .NUM(32), .NRD(2), .NWR(2), .BYPASS_EN(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tm_i(tm),
    .rd_idx_i(rd_idx), .rd_dat_o(rd_dat_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_dat_i(wr_dat),
    .set_en_i(set_en), .set_idx_i(set_idx), .flush_i(flush),
    .busy_vec_o(bv_b), .busy_cnt_o(cnt_b)
  );

  cl2_pl_exu_regfile_mp #(.XLEN(32), .NUM(32), .NRD(2), .NWR(2), .BYPASS_EN(0)) dut_nb (
    .clk_i(clk), .rst_n_i(rst_n), .tm_i(tm),
    .rd_idx_i(rd_idx), .rd_dat_o(rd_dat_n), .rd_busy_o(rd_busy_n),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_dat_i(wr_dat),
    .set_en_i(set_en), .set_idx_i(set_idx), .flush_i(flush),
    .busy_vec_o(bv_n), .busy_cnt_o(cnt_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tm = 1'b0; rd_idx = '0; wr_en = '0; wr_idx = '0; wr_dat = '0;
    set_en = 1'b0; set_idx = '0; flush = 1'b0;
    #3;
    check("reset_cnt", 64'(cnt_b), 64'd0);
    check("reset_vec", 64'(bv_b), 64'd0);
    check("reset_rd", rd_dat_b, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Every index reads zero and not busy, then a write to x0 is ignored.
    for (int i = 0; i < 32; i++) begin
      rd_idx = {5'(i), 5'(i)};
      #1;
      check("init_rd_dat", rd_dat_b, 64'd0);
      check("init_rd_busy", 64'(rd_busy_b), 64'd0);
    end
    rd_idx = '0;
    wr_en = 2'b01; wr_idx = {5'd0, 5'd0}; wr_dat = {32'h0, 32'hDEADBEEF};
    #1;
    check("x0_bypass", rd_dat_b, 64'd0);
    @(negedge clk);
    wr_en = '0;
    #1;
    check("x0_read", rd_dat_b, 64'd0);
    check("x0_read_nb", rd_dat_n, 64'd0);

    // 2. Same-cycle bypass differs from the next-cycle read without bypass.
    wr_en = 2'b01; wr_idx = {5'd0, 5'd5}; wr_dat = {32'h0, 32'h12345678};
    rd_idx = {5'd5, 5'd0};
    #1;
    check("byp_x5", 64'(rd_dat_b[63:32]), 64'h12345678);
    check("nobyp_x5_old", 64'(rd_dat_n[63:32]), 64'h0);
    @(negedge clk);
    wr_en = '0;
    #1;
    check("nobyp_x5_new", 64'(rd_dat_n[63:32]), 64'h12345678);
    check("byp_x5_stored", 64'(rd_dat_b[63:32]), 64'h12345678);

    // 3. Two ports write x7 in the same cycle, and the higher port wins.
    wr_en = 2'b11; wr_idx = {5'd7, 5'd7}; wr_dat = {32'h5555FFFF, 32'hAAAA0000};
    rd_idx = {5'd0, 5'd7};
    #1;
    check("byp_x7_prio", 64'(rd_dat_b[31:0]), 64'h5555FFFF);
    @(negedge clk);
    wr_en = '0;
    #1;
    check("x7_stored", 64'(rd_dat_b[31:0]), 64'h5555FFFF);
    check("x7_stored_nb", 64'(rd_dat_n[31:0]), 64'h5555FFFF);

    // 4. Set x3, then clear it with a writeback.
    set_en = 1'b1; set_idx = 5'd3; rd_idx = {5'd0, 5'd3};
    #1;
    check("set_not_same_cycle", 64'(rd_busy_b[0]), 64'd0);
    @(negedge clk);
    set_en = 1'b0;
    #1;
    check("x3_vec", 64'(bv_b), 64'h8);
    check("x3_cnt", 64'(cnt_b), 64'd1);
    check("x3_rd_busy", 64'(rd_busy_b[0]), 64'd1);
    check("x3_rd_busy_nb", 64'(rd_busy_n[0]), 64'd1);
    wr_en = 2'b01; wr_idx = {5'd0, 5'd3}; wr_dat = {32'h0, 32'h33};
    #1;
    check("x3_busy_byp", 64'(rd_busy_b[0]), 64'd0);
    check("x3_busy_nobyp", 64'(rd_busy_n[0]), 64'd1);
    @(negedge clk);
    wr_en = '0;
    #1;
    check("x3_cleared", 64'(bv_b), 64'd0);
    check("x3_cleared_nb", 64'(bv_n), 64'd0);
    check("x3_cnt0", 64'(cnt_b), 64'd0);

    // 5. Set beats clear on the same index, and flush beats set.
    set_en = 1'b1; set_idx = 5'd9;
    wr_en = 2'b01; wr_idx = {5'd0, 5'd9}; wr_dat = {32'h0, 32'h99};
    @(negedge clk);
    wr_en = '0; set_idx = 5'd4; rd_idx = {5'd0, 5'd9};
    #1;
    check("x9_set_wins", 64'(bv_b), 64'h200);
    check("x9_data", 64'(rd_dat_b[31:0]), 64'h99);
    check("x9_rd_busy", 64'(rd_busy_b[0]), 64'd1);
    @(negedge clk);
    set_idx = 5'd6;
    @(negedge clk);
    set_en = 1'b0;
    #1;
    check("three_busy_vec", 64'(bv_b), 64'h250);
    check("three_busy_cnt", 64'(cnt_b), 64'd3);
    flush = 1'b1; set_en = 1'b1; set_idx = 5'd8;
    @(negedge clk);
    flush = 1'b0; set_en = 1'b0;
    #1;
    check("flush_vec", 64'(bv_b), 64'd0);
    check("flush_cnt", 64'(cnt_b), 64'd0);
    check("flush_vec_nb", 64'(bv_n), 64'd0);

    // 6. Fill the scoreboard, then assert reset in the middle of a cycle.
    for (int i = 1; i < 32; i++) begin
      set_en = 1'b1; set_idx = 5'(i);
      @(negedge clk);
      #1;
      check("fill_cnt", 64'(cnt_b), 64'(i));
    end
    set_en = 1'b0;
    #1;
    check("fill_vec", 64'(bv_b), 64'hFFFFFFFE);
    wr_en = 2'b01; wr_idx = {5'd0, 5'd5}; wr_dat = {32'h0, 32'hFEED};
    rd_idx = {5'd7, 5'd5};
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_vec", 64'(bv_b), 64'd0);
    check("rst_cnt", 64'(cnt_b), 64'd0);
    check("rst_rd_dat", rd_dat_b, 64'd0);
    check("rst_rd_dat_nb", rd_dat_n, 64'd0);
    check("rst_rd_busy", 64'(rd_busy_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; wr_en = '0;
    #1;
    check("post_rst_data", rd_dat_b, 64'd0);
    set_en = 1'b1; set_idx = 5'd0;
    @(negedge clk);
    set_en = 1'b0;
    #1;
    check("x0_set_vec", 64'(bv_b), 64'd0);
    check("x0_set_cnt", 64'(cnt_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
